// File: rtl/alu_seq_if.sv
// Request/result bus for alu_seq.
// Signals:
//   a_i, b_i     operands (WIDTH bits)
//   op_i         opcode (3 bits)
//   in_valid_i   request valid          in_ready_o   block can accept a request
//   alu_o        result (WIDTH bits)    flags_o      {N,V,C,Z}
//   out_valid_o  result valid           out_ready_i  consumer takes the result
//   busy_o       multiply in progress
// Modports: master drives requests and consumes results; slave is the ALU.
interface alu_seq_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic [2:0]       op_i;
  logic             in_valid_i;
  logic             in_ready_o;
  logic [WIDTH-1:0] alu_o;
  logic [3:0]       flags_o;
  logic             out_valid_o;
  logic             out_ready_i;
  logic             busy_o;

  modport master (
    output a_i, b_i, op_i, in_valid_i, out_ready_i,
    input  in_ready_o, alu_o, flags_o, out_valid_o, busy_o
  );

  modport slave (
    input  a_i, b_i, op_i, in_valid_i, out_ready_i,
    output in_ready_o, alu_o, flags_o, out_valid_o, busy_o
  );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU with a valid/ready request side and a valid/ready result side.
// Single-cycle ops (ADD, SUB, AND, OR, XOR, SHL, SHR) register their result on the
// accept edge; MUL runs an iterative shift-add, one multiplier bit per cycle, and
// presents its result on the WIDTH-th edge after acceptance.
// Ports:
//   clk_i   clock, rising edge
//   rst_ni  asynchronous active-low reset
//   bus     alu_seq_if slave modport (operands, opcode, handshakes, result, flags, busy)
// Configuration:
//   ALU_SEQ_FLAGS_EN  when defined, flags_o = {N,V,C,Z} of each result;
//                     otherwise flags_o is tied to zero and no flag logic exists.
module alu_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  alu_seq_if.slave   bus
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  localparam logic [2:0] OpAdd = 3'b000;
  localparam logic [2:0] OpSub = 3'b001;
  localparam logic [2:0] OpAnd = 3'b010;
  localparam logic [2:0] OpOr  = 3'b011;
  localparam logic [2:0] OpXor = 3'b100;
  localparam logic [2:0] OpShl = 3'b101;
  localparam logic [2:0] OpShr = 3'b110;
  localparam logic [2:0] OpMul = 3'b111;

  typedef enum logic [0:0] {StIdle, StMul} state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [WIDTH-1:0]   alu_q, alu_d;
  logic               out_valid_q, out_valid_d;

  logic               in_ready;
  logic               accept;
  logic               load_alu;
  logic               mul_done;
  logic [WIDTH-1:0]   comb_res;
  logic [2*WIDTH-1:0] mul_sum;

  // Accepting on the same edge that the pending result is consumed keeps
  // back-to-back requests gap-free.
  assign in_ready = (state_q == StIdle) && (!out_valid_q || bus.out_ready_i);
  assign accept   = bus.in_valid_i && in_ready;

  // Single-cycle result, computed straight from the bus on the accept edge.
  always_comb begin
    comb_res = '0;
    unique case (bus.op_i)
      OpAdd:   comb_res = bus.a_i + bus.b_i;
      OpSub:   comb_res = bus.a_i - bus.b_i;
      OpAnd:   comb_res = bus.a_i & bus.b_i;
      OpOr:    comb_res = bus.a_i | bus.b_i;
      OpXor:   comb_res = bus.a_i ^ bus.b_i;
      OpShl:   comb_res = bus.a_i << 1;
      OpShr:   comb_res = bus.a_i >> 1;
      OpMul:   comb_res = '0;
      default: comb_res = '0;
    endcase
  end

  // Partial-product accumulation for the current multiplier bit.
  assign mul_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    alu_d       = alu_q;
    out_valid_d = out_valid_q && !bus.out_ready_i;
    load_alu    = 1'b0;
    mul_done    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (bus.op_i == OpMul) begin
            state_d  = StMul;
            cnt_d    = '0;
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, bus.a_i};
            mplier_d = bus.b_i;
          end else begin
            alu_d       = comb_res;
            out_valid_d = 1'b1;
            load_alu    = 1'b1;
          end
        end
      end
      StMul: begin
        acc_d    = mul_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WIDTH - 1)) begin
          state_d     = StIdle;
          alu_d       = mul_sum[WIDTH-1:0];
          out_valid_d = 1'b1;
          mul_done    = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      alu_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      alu_q       <= alu_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifdef ALU_SEQ_FLAGS_EN
  logic [3:0] flags_q, flags_d;
  logic [3:0] alu_flags;
  logic       flag_c;
  logic       flag_v;

  always_comb begin
    flag_c = 1'b0;
    flag_v = 1'b0;
    unique case (bus.op_i)
      OpAdd: begin
        // Unsigned wrap means carry-out.
        flag_c = comb_res < bus.a_i;
        flag_v = (bus.a_i[WIDTH-1] == bus.b_i[WIDTH-1]) &&
                 (comb_res[WIDTH-1] != bus.a_i[WIDTH-1]);
      end
      OpSub: begin
        flag_c = bus.a_i < bus.b_i;
        flag_v = (bus.a_i[WIDTH-1] != bus.b_i[WIDTH-1]) &&
                 (comb_res[WIDTH-1] != bus.a_i[WIDTH-1]);
      end
      OpShl:   flag_c = bus.a_i[WIDTH-1];
      OpShr:   flag_c = bus.a_i[0];
      default: begin
        flag_c = 1'b0;
        flag_v = 1'b0;
      end
    endcase
  end

  assign alu_flags = {comb_res[WIDTH-1], flag_v, flag_c, ~|comb_res};

  always_comb begin
    flags_d = flags_q;
    if (load_alu) begin
      flags_d = alu_flags;
    end else if (mul_done) begin
      flags_d = {mul_sum[WIDTH-1], 1'b0, |mul_sum[2*WIDTH-1:WIDTH], ~|mul_sum[WIDTH-1:0]};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      flags_q <= '0;
    end else begin
      flags_q <= flags_d;
    end
  end

  assign bus.flags_o = flags_q;
`else
  assign bus.flags_o = 4'h0;
`endif

  assign bus.in_ready_o  = in_ready;
  assign bus.alu_o       = alu_q;
  assign bus.out_valid_o = out_valid_q;
  assign bus.busy_o      = (state_q == StMul);

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

  localparam logic [3:0] FMask =
`ifdef ALU_SEQ_FLAGS_EN
    4'hF;
`else
    4'h0;
`endif

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  alu_seq_if #(.WIDTH(8)) bus ();

  alu_seq #(.WIDTH(8)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Single-cycle op with out_ready_i held high: result one cycle after accept,
  // consumed on the following edge.
  task automatic do_alu(input string tag, input logic [2:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] exp_alu,
                        input logic [3:0] exp_flags);
    @(negedge clk);
    bus.op_i       = op;
    bus.a_i        = a;
    bus.b_i        = b;
    bus.in_valid_i = 1'b1;
    chk({tag, "_in_ready"}, 32'(bus.in_ready_o), 32'd1);
    @(negedge clk);
    bus.in_valid_i = 1'b0;
    chk({tag, "_out_valid"}, 32'(bus.out_valid_o), 32'd1);
    chk({tag, "_alu"}, 32'(bus.alu_o), 32'(exp_alu));
    chk({tag, "_flags"}, 32'(bus.flags_o), 32'(exp_flags & FMask));
    @(negedge clk);
    chk({tag, "_consumed"}, 32'(bus.out_valid_o), 32'd0);
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    rst_n          = 1'b0;
    bus.a_i        = '0;
    bus.b_i        = '0;
    bus.op_i       = '0;
    bus.in_valid_i = 1'b0;
    bus.out_ready_i = 1'b0;

    #12;
    chk("rst_alu", 32'(bus.alu_o), 32'd0);
    chk("rst_flags", 32'(bus.flags_o), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid_o), 32'd0);
    chk("rst_busy", 32'(bus.busy_o), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready_o), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready_i = 1'b1;

    // flags are {N,V,C,Z}
    do_alu("add_aa_aa", 3'b000, 8'hAA, 8'hAA, 8'h54, 4'b0110);
    do_alu("add_7f_01", 3'b000, 8'h7F, 8'h01, 8'h80, 4'b1100);
    do_alu("sub_aa_aa", 3'b001, 8'hAA, 8'hAA, 8'h00, 4'b0001);
    do_alu("sub_01_02", 3'b001, 8'h01, 8'h02, 8'hFF, 4'b1010);
    do_alu("and",       3'b010, 8'hF0, 8'h3C, 8'h30, 4'b0000);
    do_alu("or_zero",   3'b011, 8'h00, 8'h00, 8'h00, 4'b0001);
    do_alu("shl_81",    3'b101, 8'h81, 8'h00, 8'h02, 4'b0010);
    do_alu("shr_81",    3'b110, 8'h81, 8'h00, 8'h40, 4'b0010);

    // MUL 0F*11 with operands scrambled and a competing request during iteration.
    @(negedge clk);
    bus.op_i       = 3'b111;
    bus.a_i        = 8'h0F;
    bus.b_i        = 8'h11;
    bus.in_valid_i = 1'b1;
    chk("mul1_in_ready", 32'(bus.in_ready_o), 32'd1);
    @(negedge clk);
    bus.op_i = 3'b000;
    bus.a_i  = 8'h33;
    bus.b_i  = 8'h44;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("mul1_busy_%0d", i), 32'(bus.busy_o), 32'd1);
      chk($sformatf("mul1_nvalid_%0d", i), 32'(bus.out_valid_o), 32'd0);
      chk($sformatf("mul1_nready_%0d", i), 32'(bus.in_ready_o), 32'd0);
      if (i == 7) bus.in_valid_i = 1'b0;
      @(negedge clk);
    end
    chk("mul1_out_valid", 32'(bus.out_valid_o), 32'd1);
    chk("mul1_busy_done", 32'(bus.busy_o), 32'd0);
    chk("mul1_alu", 32'(bus.alu_o), 32'h0000_00FF);
    chk("mul1_flags", 32'(bus.flags_o), 32'(4'b1000 & FMask));
    @(negedge clk);
    chk("mul1_consumed", 32'(bus.out_valid_o), 32'd0);
    chk("mul1_no_dup", 32'(bus.busy_o), 32'd0);

    // MUL FF*FF: low byte 01, high byte nonzero.
    bus.op_i       = 3'b111;
    bus.a_i        = 8'hFF;
    bus.b_i        = 8'hFF;
    bus.in_valid_i = 1'b1;
    @(negedge clk);
    bus.in_valid_i = 1'b0;
    repeat (8) @(negedge clk);
    chk("mul2_out_valid", 32'(bus.out_valid_o), 32'd1);
    chk("mul2_alu", 32'(bus.alu_o), 32'h0000_0001);
    chk("mul2_flags", 32'(bus.flags_o), 32'(4'b0010 & FMask));
    @(negedge clk);

    // XOR held under back-pressure, then consume + accept on the same edge.
    bus.out_ready_i = 1'b0;
    bus.op_i        = 3'b100;
    bus.a_i         = 8'hAA;
    bus.b_i         = 8'h55;
    bus.in_valid_i  = 1'b1;
    @(negedge clk);
    bus.op_i = 3'b000;
    bus.a_i  = 8'h01;
    bus.b_i  = 8'h02;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("xor_hold_valid_%0d", i), 32'(bus.out_valid_o), 32'd1);
      chk($sformatf("xor_hold_alu_%0d", i), 32'(bus.alu_o), 32'h0000_00FF);
      chk($sformatf("xor_hold_flags_%0d", i), 32'(bus.flags_o), 32'(4'b1000 & FMask));
      chk($sformatf("xor_hold_nready_%0d", i), 32'(bus.in_ready_o), 32'd0);
      @(negedge clk);
    end
    bus.out_ready_i = 1'b1;
    #1;
    chk("xor_ready_passthru", 32'(bus.in_ready_o), 32'd1);
    @(negedge clk);
    bus.in_valid_i = 1'b0;
    chk("b2b_add_valid", 32'(bus.out_valid_o), 32'd1);
    chk("b2b_add_alu", 32'(bus.alu_o), 32'h0000_0003);
    chk("b2b_add_flags", 32'(bus.flags_o), 32'd0);
    @(negedge clk);
    chk("b2b_add_consumed", 32'(bus.out_valid_o), 32'd0);

    // Reset on the 4th MUL cycle aborts with no result.
    bus.op_i       = 3'b111;
    bus.a_i        = 8'h0F;
    bus.b_i        = 8'h11;
    bus.in_valid_i = 1'b1;
    @(negedge clk);
    bus.in_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_busy_before", 32'(bus.busy_o), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_alu", 32'(bus.alu_o), 32'd0);
    chk("abort_flags", 32'(bus.flags_o), 32'd0);
    chk("abort_out_valid", 32'(bus.out_valid_o), 32'd0);
    chk("abort_busy", 32'(bus.busy_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_in_ready", 32'(bus.in_ready_o), 32'd1);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("abort_no_result_%0d", i), 32'(bus.out_valid_o), 32'd0);
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Parameters
REQ-001 The block SHALL have parameter WIDTH, default 8, operand and result width in bits; legal values 4..32.

Interface
REQ-002 The block SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_ni, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port a_i, input, WIDTH, operand A.
REQ-005 The block SHALL have port b_i, input, WIDTH, operand B.
REQ-006 The block SHALL have port op_i, input, 3, opcode.
REQ-007 The block SHALL have port in_valid_i, input, 1, operand/opcode valid.
REQ-008 The block SHALL have port in_ready_o, output, 1, block can accept.
REQ-009 The block SHALL have port alu_o, output, WIDTH, result.
REQ-010 The block SHALL have port flags_o, output, 4, {N,V,C,Z}.
REQ-011 The block SHALL have port out_valid_o, output, 1, result valid.
REQ-012 The block SHALL have port out_ready_i, input, 1, consumer accepts result.
REQ-013 The block SHALL have port busy_o, output, 1, high while a multiply iterates.

Function
REQ-014 The block SHALL decode opcodes: 000 ADD, 001 SUB (a-b), 010 AND, 011 OR, 100 XOR, 101 SHL a by 1, 110 SHR logical a by 1, 111 MUL (low WIDTH bits of a*b, unsigned).
REQ-015 The block SHALL accept a request on a rising edge where in_valid_i=1 and in_ready_o=1.
REQ-016 in_ready_o SHALL equal (state==IDLE) and (out_valid_o==0 or out_ready_i==1); a new request is accepted on the same edge the previous result is consumed.
REQ-017 The FSM SHALL have states IDLE, MUL; IDLE->MUL on accepting op 111; MUL->IDLE when the iteration counter reaches WIDTH.
REQ-018 Ops 000-110 SHALL register alu_o/flags_o on the accept edge; out_valid_o high the following cycle (latency 1).
REQ-019 MUL SHALL be iterative shift-add, one bit of b per cycle; alu_o/flags_o loaded and out_valid_o set on the WIDTH-th edge after the accept edge; busy_o=1 in state MUL.
REQ-020 While out_valid_o=1 and out_ready_i=0, alu_o and flags_o SHALL hold stable; out_valid_o clears on the consuming edge unless a new result loads on that edge.
REQ-021 Z SHALL be result==0; N SHALL be result MSB.
REQ-022 C SHALL be: ADD carry-out; SUB borrow (a<b unsigned); SHL a[WIDTH-1]; SHR a[0]; MUL 1 if upper WIDTH bits of the full product are nonzero; otherwise 0.
REQ-023 V SHALL be signed two's-complement overflow for ADD/SUB, 0 for all other ops.
REQ-024 Operands and opcode SHALL be captured on accept; changes on a_i/b_i/op_i during MUL SHALL not affect the result.
REQ-025 in_valid_i during MUL SHALL be ignored (in_ready_o=0), no request lost or duplicated.

Reset
REQ-026 On rst_ni=0, the block SHALL asynchronously force state IDLE, alu_o=0, flags_o=0, out_valid_o=0, busy_o=0, iteration counter=0.
REQ-027 Reset mid-MUL SHALL abort the operation with no result ever presented; in_ready_o=1 on the first cycle after rst_ni deasserts.

Configuration
REQ-028 With macro ALU_SEQ_FLAGS_EN defined, flags_o SHALL be computed per REQ-021..023; without it flags_o SHALL be constant 0 and no flag logic synthesised.

Verification (WIDTH=8, ALU_SEQ_FLAGS_EN defined unless noted)
REQ-029 ADD a=AA b=AA -> alu_o=54, flags_o N0 V1 C1 Z0, out_valid_o one cycle after accept.
REQ-030 SUB a=AA b=AA -> alu_o=00, Z=1 C=0 V=0; SUB a=01 b=02 -> FF, C=1 N=1.
REQ-031 MUL a=0F b=11 -> FF, C=0, out_valid_o exactly 8 edges after accept, busy_o high 8 cycles; MUL FF*FF -> 01, C=1.
REQ-032 XOR a=AA b=55 with out_ready_i=0 for 5 cycles -> alu_o=FF held, in_ready_o=0; raise out_ready_i with next ADD valid -> consumed and accepted on same edge, no gap.
REQ-033 Assert rst_ni=0 on 4th MUL cycle -> all outputs 0 immediately, no out_valid_o pulse, in_ready_o=1 after release.
REQ-034 Without ALU_SEQ_FLAGS_EN, repeat REQ-029 -> alu_o=54, flags_o=0.
